input_cond: RTL and testbench
=============================

# input_cond

Conditions raw player inputs before they reach the mode/state controller: synchronizes and edge-detects the mouse click, debounces the board push-button, and latches/clamps the mouse pointer once per frame. Optionally integrates two push-buttons into the second player's paddle position. Sits directly upstream of the top-level control block, driving its `mouse_left`, `button`, `xpos`, `ypos` and `ypos_sec` inputs as single-cycle pulses and frame-stable coordinates.

## Interface
Parameters:
- `DEB_CYCLES`, 650_000: cycles a synchronized button level must persist before it is accepted (10 ms at 65 MHz).
- `XMAX`, 1023: upper clamp for `xpos`.
- `YMAX`, 767: upper clamp for `ypos`.
- `SEC_STEP`, 4: paddle move per frame, pixels.
- `SEC_YMAX`, 667: upper clamp for `ypos_sec`.
- `SEC_Y_RST`, 334: reset/idle value of `ypos_sec`.

Ports (one clock `clk`; reset `rst` synchronous, active-high):
- `clk`  in  1  pixel clock.
- `rst`  in  1  synchronous active-high reset.
- `vsync_in`  in  1  frame sync from the timing generator; rising edge = frame boundary.
- `mouse_left_in`  in  1  raw left-button level from mouse controller (async).
- `button_in`  in  1  raw board push-button (async, bouncing).
- `btn_up`, `btn_dn`  in  1 each  raw second-player buttons (async, bouncing).
- `xpos_in`, `ypos_in`  in  12 each  raw mouse coordinates.
- `mouse_left`  out  1  one-cycle pulse per click press.
- `button`  out  1  one-cycle pulse per debounced press.
- `xpos`, `ypos`  out  12 each  frame-latched, clamped coordinates.
- `ypos_sec`  out  12  second paddle position.

## Operation
- Every async input passes a 2-FF synchronizer first; nothing downstream uses raw levels.
- Mouse click: no debounce; `mouse_left` = 1 for exactly one cycle on 0→1 of the synchronized level. Held button yields one pulse only.
- Debouncers (`button_in`, `btn_up`, `btn_dn`, independent): stable level `s`, counter `c`. Sync level ≠ `s` → `c` increments; sync level = `s` → `c` cleared. When `c` reaches `DEB_CYCLES-1` while still differing, `s` flips and `c` clears. Any glitch shorter than `DEB_CYCLES` cycles is ignored.
- `button` = one-cycle pulse on 0→1 of debounced `s`; release produces nothing.
- Frame strobe `fs`: `vsync_in` registered to `vs_q`; `fs = vsync_in & ~vs_q`.
- On `fs`: `xpos <= min(xpos_in, XMAX)`, `ypos <= min(ypos_in, YMAX)`. Unsigned compare, full 12 bits. Between strobes outputs hold.
- Paddle (when compiled in): on `fs`, debounced up only → `ypos_sec <= (ypos_sec < SEC_STEP) ? 0 : ypos_sec - SEC_STEP`; dn only → `ypos_sec <= min(ypos_sec + SEC_STEP, SEC_YMAX)` computed in 13 bits; both or neither → hold.

## Timing
- Reset values: `mouse_left`=0, `button`=0, `xpos`=0, `ypos`=0, `ypos_sec`=`SEC_Y_RST`; all synchronizers, `vs_q`, debounced levels, counters = 0.
- `mouse_left` pulse: 3 cycles after the raw edge is sampled (2 sync + 1 edge register).
- `button` pulse: 2 sync + `DEB_CYCLES` + 1 cycles after a clean raw edge.
- `xpos`/`ypos`/`ypos_sec` update on the clock edge following the cycle where `fs`=1; stable for the rest of the frame.
- Reset mid-count: debounce progress lost; a held button after reset is re-debounced and pulses once.
- Button held across reset with `vsync_in` high: no spurious `fs` until `vsync_in` falls and rises again.
- All outputs registered; no combinational input→output path.

## Configuration
- `INPUT_COND_SEC_PADDLE_EN` defined: `btn_up`/`btn_dn` debouncers and paddle integrator present as above.
- Not defined: those debouncers and integrator removed; `ypos_sec` constant `SEC_Y_RST`; `btn_up`/`btn_dn` ignored (ports kept).

## Test plan
- `mouse_left_in` high for 1000 cycles → exactly one `mouse_left` pulse, 3 cycles after the rise.
- `DEB_CYCLES`=16; `button_in` bounces (3-cycle pulses ×5) then holds high 40 cycles → one `button` pulse, 19 cycles after the final rise; no pulse on release.
- `xpos_in`=1500, `ypos_in`=800 change mid-frame → `xpos`/`ypos` unchanged until next `vsync_in` rise, then 1023/767.
- Paddle enabled, `ypos_sec`=2, `btn_up` held 2 frames → 0 then 0; `btn_dn` held from 665 → 667, stays 667; both held → unchanged.
- `rst` asserted while `button_in` debounce counter at 10 → all outputs reset values; held button released after reset yields no pulse, re-press yields one.
- Macro undefined: toggle `btn_up`/`btn_dn` over 10 frames → `ypos_sec` constant 334.

Source files
------------

// File: rtl/input_cond.sv
// input_cond
//
// Conditions raw player inputs for the mode/state controller:
//   - 2-FF synchronizes every asynchronous input
//   - turns the mouse left button into a one-cycle press pulse
//   - debounces the board push-button and emits a one-cycle press pulse
//   - latches and clamps the mouse coordinates once per frame
//   - optionally integrates two push-buttons into a second paddle position
//
// Optional feature macro: INPUT_COND_SEC_PADDLE_EN
//   defined     : btn_up/btn_dn debouncers and paddle integrator built in
//   not defined : ypos_sec is the constant SEC_Y_RST, btn_up/btn_dn ignored
//
// Ports:
//   clk            in   pixel clock
//   rst            in   synchronous active-high reset
//   vsync_in       in   frame sync, rising edge marks the frame boundary
//   mouse_left_in  in   raw mouse left-button level (async)
//   button_in      in   raw board push-button (async, bouncing)
//   btn_up, btn_dn in   raw second-player buttons (async, bouncing)
//   xpos_in        in   [11:0] raw mouse x
//   ypos_in        in   [11:0] raw mouse y
//   mouse_left     out  one-cycle pulse per click press
//   button         out  one-cycle pulse per debounced press
//   xpos, ypos     out  [11:0] frame-latched, clamped coordinates
//   ypos_sec       out  [11:0] second paddle position

// Synchronizer plus debouncer for one raw button. The counter runs only
// while the synchronized level differs from the accepted level; any agreement
// clears it, so a glitch shorter than DEB_CYCLES never gets through.
module input_cond_deb #(
  parameter int DEB_CYCLES = 650_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 != level) begin
        if (cnt == C_LAST) begin
          level <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

module input_cond #(
  parameter int DEB_CYCLES = 650_000,
  parameter int XMAX       = 1023,
  parameter int YMAX       = 767,
  parameter int SEC_STEP   = 4,
  parameter int SEC_YMAX   = 667,
  parameter int SEC_Y_RST  = 334
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vsync_in,
  input  logic        mouse_left_in,
  input  logic        button_in,
  input  logic        btn_up,
  input  logic        btn_dn,
  input  logic [11:0] xpos_in,
  input  logic [11:0] ypos_in,
  output logic        mouse_left,
  output logic        button,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic [11:0] ypos_sec
);

  localparam logic [11:0] XMAX_L      = 12'(XMAX);
  localparam logic [11:0] YMAX_L      = 12'(YMAX);
  localparam logic [11:0] SEC_Y_RST_L = 12'(SEC_Y_RST);

  // ---------------------------------------------------------------- mouse
  logic ml_s1;
  logic ml_s2;
  logic ml_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ml_s1      <= 1'b0;
      ml_s2      <= 1'b0;
      ml_q       <= 1'b0;
      mouse_left <= 1'b0;
    end else begin
      ml_s1      <= mouse_left_in;
      ml_s2      <= ml_s1;
      ml_q       <= ml_s2;
      mouse_left <= ml_s2 & ~ml_q;
    end
  end

  // --------------------------------------------------------- push-button
  logic btn_lvl;
  logic btn_q;

  input_cond_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_btn (
    .clk   (clk),
    .rst   (rst),
    .raw   (button_in),
    .level (btn_lvl)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_q  <= 1'b0;
      button <= 1'b0;
    end else begin
      btn_q  <= btn_lvl;
      button <= btn_lvl & ~btn_q;
    end
  end

  // --------------------------------------------------------- frame strobe
  // vs_armed stays low after reset until vsync_in has been seen low, so a
  // vsync_in held high across reset does not fake a frame boundary.
  logic vs_q;
  logic vs_armed;
  logic fs;

  assign fs = vsync_in & ~vs_q & vs_armed;

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_q     <= 1'b0;
      vs_armed <= 1'b0;
    end else begin
      vs_q     <= vsync_in;
      vs_armed <= vs_armed | ~vsync_in;
    end
  end

  // ----------------------------------------------------------- coordinates
  always_ff @(posedge clk) begin
    if (rst) begin
      xpos <= '0;
      ypos <= '0;
    end else if (fs) begin
      xpos <= (xpos_in > XMAX_L) ? XMAX_L : xpos_in;
      ypos <= (ypos_in > YMAX_L) ? YMAX_L : ypos_in;
    end
  end

  // ---------------------------------------------------------- second paddle
`ifdef INPUT_COND_SEC_PADDLE_EN
  localparam logic [11:0] SEC_STEP_L = 12'(SEC_STEP);
  localparam logic [12:0] SEC_YMAX_W = 13'(SEC_YMAX);

  logic        up_lvl;
  logic        dn_lvl;
  logic [12:0] sec_sum;

  input_cond_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_up),
    .level (up_lvl)
  );

  input_cond_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dn (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_dn),
    .level (dn_lvl)
  );

  // One extra bit so the step past the top cannot wrap before the clamp.
  assign sec_sum = {1'b0, ypos_sec} + {1'b0, SEC_STEP_L};

  always_ff @(posedge clk) begin
    if (rst) begin
      ypos_sec <= SEC_Y_RST_L;
    end else if (fs) begin
      if (up_lvl && !dn_lvl) begin
        ypos_sec <= (ypos_sec < SEC_STEP_L) ? 12'd0 : ypos_sec - SEC_STEP_L;
      end else if (dn_lvl && !up_lvl) begin
        ypos_sec <= (sec_sum > SEC_YMAX_W) ? SEC_YMAX_W[11:0] : sec_sum[11:0];
      end
    end
  end
`else
  localparam logic [11:0] SEC_STEP_L = 12'(SEC_STEP);
  localparam logic [11:0] SEC_YMAX_L = 12'(SEC_YMAX);

  // Paddle logic is absent; the buttons and paddle parameters are tied off.
  logic unused_sec;
  assign unused_sec = ^{btn_up, btn_dn, SEC_STEP_L, SEC_YMAX_L};

  assign ypos_sec = SEC_Y_RST_L;
`endif

endmodule

// File: tb/tb_input_cond.sv
module tb_input_cond;

  logic        clk;
  logic        rst;
  logic        vsync_in;
  logic        mouse_left_in;
  logic        button_in;
  logic        btn_up;
  logic        btn_dn;
  logic [11:0] xpos_in;
  logic [11:0] ypos_in;
  logic        mouse_left;
  logic        button;
  logic [11:0] xpos;
  logic [11:0] ypos;
  logic [11:0] ypos_sec;

  int vectors;
  int miscompares;

  input_cond #(
    .DEB_CYCLES (16),
    .XMAX       (1023),
    .YMAX       (767),
    .SEC_STEP   (4),
    .SEC_YMAX   (667),
    .SEC_Y_RST  (334)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .vsync_in      (vsync_in),
    .mouse_left_in (mouse_left_in),
    .button_in     (button_in),
    .btn_up        (btn_up),
    .btn_dn        (btn_dn),
    .xpos_in       (xpos_in),
    .ypos_in       (ypos_in),
    .mouse_left    (mouse_left),
    .button        (button),
    .xpos          (xpos),
    .ypos          (ypos),
    .ypos_sec      (ypos_sec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    vsync_in = 1'b1;
    tick();
    tick();
    vsync_in = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    vectors++;
    if (mouse_left !== 1'b0 || button !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_pulses: mouse_left=%b button=%b required 0 0", mouse_left, button);
    end
    vectors++;
    if (xpos !== 12'd0 || ypos !== 12'd0) begin
      miscompares++;
      $display("FAIL reset_coords: xpos=%0d ypos=%0d required 0 0", xpos, ypos);
    end
    vectors++;
    if (ypos_sec !== 12'd334) begin
      miscompares++;
      $display("FAIL reset_ypos_sec: got %0d required 334", ypos_sec);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_mouse();
    int cnt;
    int first;
    cnt = 0;
    first = -1;
    mouse_left_in = 1'b1;
    for (int i = 1; i <= 1000; i++) begin
      tick();
      if (mouse_left === 1'b1) begin
        cnt++;
        if (first < 0) first = i;
      end
    end
    vectors++;
    if (cnt != 1) begin
      miscompares++;
      $display("FAIL mouse_pulse_count: got %0d required 1", cnt);
    end
    vectors++;
    if (first != 3) begin
      miscompares++;
      $display("FAIL mouse_pulse_latency: got %0d required 3", first);
    end
    mouse_left_in = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (mouse_left === 1'b1) cnt++;
    end
    vectors++;
    if (cnt != 0) begin
      miscompares++;
      $display("FAIL mouse_release: got %0d pulses required 0", cnt);
    end
  endtask

  task automatic test_button_bounce();
    int cnt;
    int first;
    cnt = 0;
    for (int b = 0; b < 5; b++) begin
      button_in = 1'b1;
      for (int i = 0; i < 3; i++) begin
        tick();
        if (button === 1'b1) cnt++;
      end
      button_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
        tick();
        if (button === 1'b1) cnt++;
      end
    end
    vectors++;
    if (cnt != 0) begin
      miscompares++;
      $display("FAIL button_bounce: got %0d pulses required 0", cnt);
    end
    cnt = 0;
    first = -1;
    button_in = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (button === 1'b1) begin
        cnt++;
        if (first < 0) first = i;
      end
    end
    vectors++;
    if (cnt != 1 || first != 19) begin
      miscompares++;
      $display("FAIL button_press: got %0d pulses at %0d required 1 at 19", cnt, first);
    end
    cnt = 0;
    button_in = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (button === 1'b1) cnt++;
    end
    vectors++;
    if (cnt != 0) begin
      miscompares++;
      $display("FAIL button_release: got %0d pulses required 0", cnt);
    end
  endtask

  task automatic test_frame_latch();
    logic [11:0] tbl_in_x [7];
    logic [11:0] tbl_in_y [7];
    logic [11:0] tbl_ex_x [7];
    logic [11:0] tbl_ex_y [7];
    logic [11:0] prev_x;
    logic [11:0] prev_y;
    tbl_in_x = '{12'd100, 12'd1500, 12'd0, 12'd1023, 12'd7,  12'd1024, 12'd4095};
    tbl_in_y = '{12'd200, 12'd800,  12'd0, 12'd767,  12'd9,  12'd768,  12'd4095};
    tbl_ex_x = '{12'd100, 12'd1023, 12'd0, 12'd1023, 12'd7,  12'd1023, 12'd1023};
    tbl_ex_y = '{12'd200, 12'd767,  12'd0, 12'd767,  12'd9,  12'd767,  12'd767};
    prev_x = 12'd0;
    prev_y = 12'd0;
    for (int k = 0; k < 7; k++) begin
      xpos_in = tbl_in_x[k];
      ypos_in = tbl_in_y[k];
      tick();
      tick();
      tick();
      vectors++;
      if (xpos !== prev_x || ypos !== prev_y) begin
        miscompares++;
        $display("FAIL frame_hold[%0d]: xpos=%0d ypos=%0d required %0d %0d", k, xpos, ypos, prev_x, prev_y);
      end
      frame();
      vectors++;
      if (xpos !== tbl_ex_x[k] || ypos !== tbl_ex_y[k]) begin
        miscompares++;
        $display("FAIL frame_latch[%0d]: xpos=%0d ypos=%0d required %0d %0d", k, xpos, ypos, tbl_ex_x[k], tbl_ex_y[k]);
      end
      prev_x = tbl_ex_x[k];
      prev_y = tbl_ex_y[k];
    end
  endtask

  task automatic test_reset_midcount();
    int cnt;
    int first;
    button_in = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    vsync_in = 1'b1;
    xpos_in = 12'd55;
    ypos_in = 12'd66;
    rst = 1'b1;
    tick();
    tick();
    vectors++;
    if (mouse_left !== 1'b0 || button !== 1'b0 || xpos !== 12'd0 || ypos !== 12'd0 || ypos_sec !== 12'd334) begin
      miscompares++;
      $display("FAIL midcount_reset_outputs: ml=%b btn=%b x=%0d y=%0d ys=%0d required 0 0 0 0 334",
               mouse_left, button, xpos, ypos, ypos_sec);
    end
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (button === 1'b1) cnt++;
    end
    button_in = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (button === 1'b1) cnt++;
    end
    vectors++;
    if (cnt != 0) begin
      miscompares++;
      $display("FAIL midcount_release: got %0d pulses required 0", cnt);
    end
    vectors++;
    if (xpos !== 12'd0 || ypos !== 12'd0) begin
      miscompares++;
      $display("FAIL vsync_high_across_reset: xpos=%0d ypos=%0d required 0 0", xpos, ypos);
    end
    vsync_in = 1'b0;
    tick();
    tick();
    vsync_in = 1'b1;
    tick();
    vectors++;
    if (xpos !== 12'd55 || ypos !== 12'd66) begin
      miscompares++;
      $display("FAIL first_frame_after_reset: xpos=%0d ypos=%0d required 55 66", xpos, ypos);
    end
    vsync_in = 1'b0;
    tick();
    cnt = 0;
    first = -1;
    button_in = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (button === 1'b1) begin
        cnt++;
        if (first < 0) first = i;
      end
    end
    vectors++;
    if (cnt != 1 || first != 19) begin
      miscompares++;
      $display("FAIL repress_after_reset: got %0d pulses at %0d required 1 at 19", cnt, first);
    end
    button_in = 1'b0;
    for (int i = 0; i < 30; i++) tick();
  endtask

`ifdef INPUT_COND_SEC_PADDLE_EN
  task automatic test_paddle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    btn_up = 1'b1;
    for (int i = 0; i < 25; i++) tick();
    for (int f = 0; f < 83; f++) frame();
    vectors++;
    if (ypos_sec !== 12'd2) begin
      miscompares++;
      $display("FAIL paddle_up_to_2: got %0d required 2", ypos_sec);
    end
    frame();
    vectors++;
    if (ypos_sec !== 12'd0) begin
      miscompares++;
      $display("FAIL paddle_up_floor: got %0d required 0", ypos_sec);
    end
    frame();
    vectors++;
    if (ypos_sec !== 12'd0) begin
      miscompares++;
      $display("FAIL paddle_up_stay_0: got %0d required 0", ypos_sec);
    end
    btn_up = 1'b0;
    btn_dn = 1'b1;
    for (int i = 0; i < 25; i++) tick();
    for (int f = 0; f < 166; f++) frame();
    vectors++;
    if (ypos_sec !== 12'd664) begin
      miscompares++;
      $display("FAIL paddle_dn_to_664: got %0d required 664", ypos_sec);
    end
    frame();
    vectors++;
    if (ypos_sec !== 12'd667) begin
      miscompares++;
      $display("FAIL paddle_dn_clamp: got %0d required 667", ypos_sec);
    end
    frame();
    vectors++;
    if (ypos_sec !== 12'd667) begin
      miscompares++;
      $display("FAIL paddle_dn_stay_667: got %0d required 667", ypos_sec);
    end
    btn_up = 1'b1;
    for (int i = 0; i < 25; i++) tick();
    frame();
    frame();
    vectors++;
    if (ypos_sec !== 12'd667) begin
      miscompares++;
      $display("FAIL paddle_both_hold: got %0d required 667", ypos_sec);
    end
    btn_dn = 1'b0;
    for (int i = 0; i < 25; i++) tick();
    frame();
    vectors++;
    if (ypos_sec !== 12'd663) begin
      miscompares++;
      $display("FAIL paddle_up_from_667: got %0d required 663", ypos_sec);
    end
    btn_up = 1'b0;
    for (int i = 0; i < 25; i++) tick();
    frame();
    vectors++;
    if (ypos_sec !== 12'd663) begin
      miscompares++;
      $display("FAIL paddle_neither_hold: got %0d required 663", ypos_sec);
    end
  endtask
`else
  task automatic test_sec_const();
    int bad;
    bad = 0;
    for (int f = 0; f < 10; f++) begin
      btn_up = f[0];
      btn_dn = f[1];
      for (int i = 0; i < 20; i++) tick();
      frame();
      if (ypos_sec !== 12'd334) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL sec_constant: %0d frames off, last ypos_sec=%0d required 334", bad, ypos_sec);
    end
    btn_up = 1'b0;
    btn_dn = 1'b0;
  endtask
`endif

  initial begin
    vectors       = 0;
    miscompares   = 0;
    rst           = 1'b1;
    vsync_in      = 1'b0;
    mouse_left_in = 1'b0;
    button_in     = 1'b0;
    btn_up        = 1'b0;
    btn_dn        = 1'b0;
    xpos_in       = 12'd0;
    ypos_in       = 12'd0;
    #1;
    test_reset();
    test_mouse();
    test_button_bounce();
    test_frame_latch();
    test_reset_midcount();
`ifdef INPUT_COND_SEC_PADDLE_EN
    test_paddle();
`else
    test_sec_const();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
